// File: rtl/ysyx_25060166_regfile_scb_pkg.sv
// ysyx_25060166_regfile_scb_pkg: shared sizes, register-address type and address-range helper
package ysyx_25060166_regfile_scb_pkg;

    localparam int RF_WIDTH   = 32;
    localparam int RF_REG_NUM = 16;
    localparam int AW         = 5;
    localparam int RF_CNT_W   = 2;

    typedef logic [AW-1:0] reg_addr_t;

    // True for a register that physically exists and is not the hard-wired x0.
    function automatic logic valid_rd(input reg_addr_t a, input int reg_num);
        return (a != '0) && (int'(a) < reg_num);
    endfunction

endpackage

// File: rtl/ysyx_25060166_regfile_scb_if.sv
// ysyx_25060166_regfile_scb_if: read, issue, writeback and flush bundle between ID/WB and the register file
// master: pipeline side (drives addresses, issue, writebacks, flush)
// slave : register file side (returns read data, busy flags, issue ready)
interface ysyx_25060166_regfile_scb_if
    import ysyx_25060166_regfile_scb_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NR_RD = 2
) ();
    logic [NR_RD*AW-1:0]    rd_addr;
    logic [NR_RD*WIDTH-1:0] rd_data;
    logic [NR_RD-1:0]       rd_busy;
    logic                   iss_valid;
    reg_addr_t              iss_rd;
    logic                   iss_ready;
    logic                   wb0_en;
    reg_addr_t              wb0_rd;
    logic [WIDTH-1:0]       wb0_data;
    logic                   wb0_clr;
    logic                   wb1_en;
    reg_addr_t              wb1_rd;
    logic [WIDTH-1:0]       wb1_data;
    logic                   wb1_clr;
    logic                   flush;

    modport master (
        output rd_addr, iss_valid, iss_rd, wb0_en, wb0_rd, wb0_data, wb0_clr,
               wb1_en, wb1_rd, wb1_data, wb1_clr, flush,
        input  rd_data, rd_busy, iss_ready
    );

    modport slave (
        input  rd_addr, iss_valid, iss_rd, wb0_en, wb0_rd, wb0_data, wb0_clr,
               wb1_en, wb1_rd, wb1_data, wb1_clr, flush,
        output rd_data, rd_busy, iss_ready
    );
endinterface

// File: rtl/ysyx_25060166_regfile_scb_cnt.sv
// ysyx_25060166_scb_cnt: per-register outstanding-producer counter with one increment and two decrements per cycle
// inc_i         : issue of a new producer
// dec0_i/dec1_i : retirement of a producer on writeback port 0/1
// clr_i         : pipeline flush, clears the count
// sat_o / nz_o  : count at maximum / count nonzero (from the registered count)
module ysyx_25060166_scb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec0_i,
    input  logic dec1_i,
    input  logic clr_i,
    output logic sat_o,
    output logic nz_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W+1:0] sum;

    // Two guard bits: top bit flags underflow, next one flags overflow.
    always_comb begin
        sum   = {2'b00, cnt_q} + (CNT_W+2)'(inc_i) - (CNT_W+2)'(dec0_i) - (CNT_W+2)'(dec1_i);
        cnt_d = clr_i ? '0 : sum[CNT_W+1] ? '0 : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sat_o = &cnt_q;
    assign nz_o  = |cnt_q;

    // Retiring more producers than are in flight is a pipeline protocol error.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst || clr_i) !sum[CNT_W+1]);

endmodule

// File: rtl/ysyx_25060166_regfile_scb.sv
// ysyx_25060166_regfile_scb: GPR file with two prioritised writeback ports, optional bypass and issue scoreboard
// clk, rst : clock, synchronous active-high reset
// rf       : slave side of the register-file bundle (reads, issue, writebacks, flush)
module ysyx_25060166_regfile_scb
    import ysyx_25060166_regfile_scb_pkg::*;
#(
    parameter int WIDTH   = RF_WIDTH,
    parameter int REG_NUM = RF_REG_NUM,
    parameter int NR_RD   = 2,
    parameter int BYPASS  = 1,
    parameter int CNT_W   = RF_CNT_W
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_25060166_regfile_scb_if.slave rf
);
    logic [WIDTH-1:0]   regs_q [1:REG_NUM-1];
    logic [WIDTH-1:0]   regs_d [1:REG_NUM-1];
    logic [REG_NUM-1:1] sat_v, nz_v;
    logic               sat_sel;

    // Port 1 (LSU) wins when both writebacks target the same register.
    always_comb begin
        for (int r = 1; r < REG_NUM; r++)
            regs_d[r] = (rf.wb1_en && rf.wb1_rd == AW'(r)) ? rf.wb1_data :
                        (rf.wb0_en && rf.wb0_rd == AW'(r)) ? rf.wb0_data : regs_q[r];
    end

    always_ff @(posedge clk) begin
        for (int r = 1; r < REG_NUM; r++)
            regs_q[r] <= rst ? '0 : regs_d[r];
    end

    // A flush drops any issue arriving on the same edge.
    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        ysyx_25060166_scb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_i  (rf.iss_valid && rf.iss_ready && !rf.flush && rf.iss_rd == AW'(r)),
            .dec0_i (rf.wb0_clr && rf.wb0_rd == AW'(r)),
            .dec1_i (rf.wb1_clr && rf.wb1_rd == AW'(r)),
            .clr_i  (rf.flush),
            .sat_o  (sat_v[r]),
            .nz_o   (nz_v[r])
        );
    end

    // x0 and nonexistent registers select nothing, so they never stall.
    always_comb begin
        sat_sel = 1'b0;
        for (int r = 1; r < REG_NUM; r++)
            if (rf.iss_rd == AW'(r)) sat_sel = sat_v[r];
    end

    assign rf.iss_ready = !sat_sel;

    for (genvar k = 0; k < NR_RD; k++) begin : g_rd
        reg_addr_t        a;
        logic [WIDTH-1:0] v;
        logic             b;
        assign a = rf.rd_addr[AW*k +: AW];
        // Busy follows the registered count even when bypass forwards the data.
        always_comb begin
            v = '0;
            b = 1'b0;
            for (int r = 1; r < REG_NUM; r++)
                if (a == AW'(r)) begin
                    v = regs_q[r];
                    b = nz_v[r];
                end
            if (BYPASS != 0 && valid_rd(a, REG_NUM)) begin
                if (rf.wb0_en && rf.wb0_rd == a) v = rf.wb0_data;
                if (rf.wb1_en && rf.wb1_rd == a) v = rf.wb1_data;
            end
        end
        assign rf.rd_data[WIDTH*k +: WIDTH] = v;
        assign rf.rd_busy[k]                = b;
    end

endmodule

// File: tb/tb_ysyx_25060166_regfile_scb.sv
// tb_ysyx_25060166_regfile_scb: directed checks of reads, writes, bypass, scoreboard and flush
module tb_ysyx_25060166_regfile_scb;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ysyx_25060166_regfile_scb_if #(.WIDTH(32), .NR_RD(2)) rf ();
    ysyx_25060166_regfile_scb_if #(.WIDTH(32), .NR_RD(2)) rf0 ();

    assign rf0.rd_addr   = rf.rd_addr;
    assign rf0.iss_valid = rf.iss_valid;
    assign rf0.iss_rd    = rf.iss_rd;
    assign rf0.wb0_en    = rf.wb0_en;
    assign rf0.wb0_rd    = rf.wb0_rd;
    assign rf0.wb0_data  = rf.wb0_data;
    assign rf0.wb0_clr   = rf.wb0_clr;
    assign rf0.wb1_en    = rf.wb1_en;
    assign rf0.wb1_rd    = rf.wb1_rd;
    assign rf0.wb1_data  = rf.wb1_data;
    assign rf0.wb1_clr   = rf.wb1_clr;
    assign rf0.flush     = rf.flush;

    ysyx_25060166_regfile_scb #(.BYPASS(1)) u_byp (.clk(clk), .rst(rst), .rf(rf));
    ysyx_25060166_regfile_scb #(.BYPASS(0)) u_nob (.clk(clk), .rst(rst), .rf(rf0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.rd_addr   = '0;
        rf.iss_valid = 1'b0;
        rf.iss_rd    = '0;
        rf.wb0_en    = 1'b0;
        rf.wb0_rd    = '0;
        rf.wb0_data  = '0;
        rf.wb0_clr   = 1'b0;
        rf.wb1_en    = 1'b0;
        rf.wb1_rd    = '0;
        rf.wb1_data  = '0;
        rf.wb1_clr   = 1'b0;
        rf.flush     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rf.rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // reset with state present
        rf.wb0_en = 1'b1; rf.wb0_rd = 5'd1; rf.wb0_data = 32'h1234_5678;
        rf.wb1_en = 1'b1; rf.wb1_rd = 5'd9; rf.wb1_data = 32'hCAFE_F00D;
        rf.iss_valid = 1'b1; rf.iss_rd = 5'd2;
        tick();
        idle();
        rd(5'd1, 5'd2);
        chk("pre_rst_x1", rf.rd_data[31:0], 32'h1234_5678);
        chk("pre_rst_busy_x2", 32'(rf.rd_busy[1]), 32'd1);
        rst = 1'b1;
        rf.wb0_en = 1'b1; rf.wb0_rd = 5'd1; rf.wb0_data = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        idle();
        rd(5'd1, 5'd2);
        chk("rst_x1", rf.rd_data[31:0], 32'h0);
        chk("rst_busy_x2", 32'(rf.rd_busy[1]), 32'd0);
        rd(5'd9, 5'd2);
        chk("rst_x9", rf.rd_data[31:0], 32'h0);
        rf.iss_rd = 5'd2; #1;
        chk("rst_ready", 32'(rf.iss_ready), 32'd1);
        // x0 is hard-wired
        idle();
        rf.wb0_en = 1'b1; rf.wb0_rd = 5'd0; rf.wb0_data = 32'hDEAD_BEEF;
        rd(5'd0, 5'd0);
        chk("x0_bypass", rf.rd_data[31:0], 32'h0);
        tick();
        idle();
        rd(5'd0, 5'd0);
        chk("x0_read", rf.rd_data[31:0], 32'h0);
        rf.iss_valid = 1'b1; rf.iss_rd = 5'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("x0_iss_ready", 32'(rf.iss_ready), 32'd1);
            tick();
        end
        idle();
        rd(5'd0, 5'd0);
        chk("x0_busy", 32'(rf.rd_busy[0]), 32'd0);
        // dual write to the same register
        rf.wb0_en = 1'b1; rf.wb0_rd = 5'd5; rf.wb0_data = 32'h11;
        rf.wb1_en = 1'b1; rf.wb1_rd = 5'd5; rf.wb1_data = 32'h22;
        rd(5'd5, 5'd0);
        chk("dual_byp_same", rf.rd_data[31:0], 32'h22);
        chk("dual_nob_same", rf0.rd_data[31:0], 32'h0);
        tick();
        idle();
        rd(5'd5, 5'd0);
        chk("dual_byp_after", rf.rd_data[31:0], 32'h22);
        chk("dual_nob_after", rf0.rd_data[31:0], 32'h22);
        rf.wb0_en = 1'b1; rf.wb0_rd = 5'd6; rf.wb0_data = 32'h33;
        rd(5'd5, 5'd6);
        chk("wb0_byp", rf.rd_data[63:32], 32'h33);
        chk("wb0_nob", rf0.rd_data[63:32], 32'h0);
        tick();
        idle();
        rd(5'd5, 5'd6);
        chk("wb0_nob_after", rf0.rd_data[63:32], 32'h33);
        // scoreboard on x3
        rf.iss_valid = 1'b1; rf.iss_rd = 5'd3;
        tick(); tick(); tick();
        rd(5'd3, 5'd0);
        chk("sb_busy_sat", 32'(rf.rd_busy[0]), 32'd1);
        chk("sb_ready_sat", 32'(rf.iss_ready), 32'd0);
        tick();
        #1;
        chk("sb_ready_blocked", 32'(rf.iss_ready), 32'd0);
        rf.iss_valid = 1'b0;
        rf.wb0_clr = 1'b1; rf.wb0_rd = 5'd3;
        tick();
        idle();
        rf.iss_rd = 5'd3;
        rd(5'd3, 5'd0);
        chk("sb_ready_cnt2", 32'(rf.iss_ready), 32'd1);
        rf.wb0_clr = 1'b1; rf.wb0_rd = 5'd3; rf.iss_valid = 1'b1;
        tick();
        idle();
        rf.iss_valid = 1'b1; rf.iss_rd = 5'd3;
        tick();
        idle();
        rf.iss_rd = 5'd3;
        rd(5'd3, 5'd0);
        chk("sb_net_inc_dec", 32'(rf.iss_ready), 32'd0);
        rf.wb0_clr = 1'b1; rf.wb0_rd = 5'd3;
        rf.wb1_clr = 1'b1; rf.wb1_rd = 5'd3;
        tick();
        idle();
        rf.iss_rd = 5'd3;
        rd(5'd3, 5'd0);
        chk("sb_busy_cnt1", 32'(rf.rd_busy[0]), 32'd1);
        chk("sb_ready_cnt1", 32'(rf.iss_ready), 32'd1);
        rf.wb1_clr = 1'b1; rf.wb1_rd = 5'd3;
        tick();
        idle();
        rd(5'd3, 5'd0);
        chk("sb_busy_cnt0", 32'(rf.rd_busy[0]), 32'd0);
        // flush on x7
        rf.iss_valid = 1'b1; rf.iss_rd = 5'd7;
        tick(); tick();
        idle();
        rd(5'd7, 5'd0);
        chk("fl_busy_pre", 32'(rf.rd_busy[0]), 32'd1);
        rf.flush = 1'b1;
        rf.wb1_en = 1'b1; rf.wb1_rd = 5'd7; rf.wb1_data = 32'h55;
        rf.iss_valid = 1'b1; rf.iss_rd = 5'd7;
        tick();
        idle();
        rd(5'd7, 5'd0);
        chk("fl_busy_post", 32'(rf.rd_busy[0]), 32'd0);
        chk("fl_data", rf.rd_data[31:0], 32'h55);
        chk("fl_data_nob", rf0.rd_data[31:0], 32'h55);
        rf.iss_valid = 1'b1; rf.iss_rd = 5'd7;
        tick(); tick();
        #1;
        chk("fl_issue_dropped", 32'(rf.iss_ready), 32'd1);
        idle();
        // nonexistent register x20
        rf.wb0_en = 1'b1; rf.wb0_rd = 5'd20; rf.wb0_data = 32'h99;
        rd(5'd20, 5'd4);
        chk("x20_bypass", rf.rd_data[31:0], 32'h0);
        tick();
        idle();
        rd(5'd20, 5'd4);
        chk("x20_read", rf.rd_data[31:0], 32'h0);
        chk("x20_alias_x4", rf.rd_data[63:32], 32'h0);
        chk("x20_busy", 32'(rf.rd_busy[0]), 32'd0);
        rf.iss_valid = 1'b1; rf.iss_rd = 5'd20;
        #1;
        chk("x20_ready", 32'(rf.iss_ready), 32'd1);
        tick();
        idle();
        rd(5'd20, 5'd4);
        chk("x20_busy_post", 32'(rf.rd_busy[0]), 32'd0);
        chk("x4_busy_post", 32'(rf.rd_busy[1]), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
